// File: rtl/e203_exu_oitf_pkg.sv
// Shared sizing constants for the outstanding instruction track FIFO.
// Default values mirror the core-wide configuration.
package e203_exu_oitf_pkg;

   localparam int E203_OITF_DEPTH  = 2;
   localparam int E203_ITAG_WIDTH  = 1;
   localparam int E203_RFIDX_WIDTH = 5;
   localparam int E203_PC_SIZE     = 32;

endpackage

// File: rtl/e203_exu_oitf_ptr.sv
// Circular FIFO pointer with a wrap flag.
// The flag distinguishes full from empty when both pointers coincide.
module e203_exu_oitf_ptr #(
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   output logic [PTR_W-1:0] ptr,
   output logic             flag
);

   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   // With DEPTH=1 LAST is zero, so the pointer stays at 0 and only the flag toggles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr  <= '0;
         flag <= 1'b0;
      end else if (ena) begin
         if (ptr == LAST) begin
            ptr  <= '0;
            flag <= ~flag;
         end else begin
            ptr <= ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/e203_exu_oitf.sv
// Outstanding Instruction Track FIFO: tracks in-flight long-pipe instructions,
// retires them in order and flags RAW/WAW hazards against their destinations.
module e203_exu_oitf
   import e203_exu_oitf_pkg::*;
#(
   parameter int DEPTH   = E203_OITF_DEPTH,
   parameter int ITAG_W  = E203_ITAG_WIDTH,
   parameter int RFIDX_W = E203_RFIDX_WIDTH,
   parameter int PC_W    = E203_PC_SIZE
) (
   input  logic               clk,
   input  logic               rst_n,

   output logic               dis_ready,
   input  logic               dis_ena,
   output logic [ITAG_W-1:0]  dis_ptr,
   input  logic               disp_i_rdwen,
   input  logic               disp_i_rdfpu,
   input  logic [RFIDX_W-1:0] disp_i_rdidx,
   input  logic [PC_W-1:0]    disp_i_pc,
   input  logic               disp_i_rs1en,
   input  logic               disp_i_rs2en,
   input  logic               disp_i_rs3en,
   input  logic               disp_i_rs1fpu,
   input  logic               disp_i_rs2fpu,
   input  logic               disp_i_rs3fpu,
   input  logic [RFIDX_W-1:0] disp_i_rs1idx,
   input  logic [RFIDX_W-1:0] disp_i_rs2idx,
   input  logic [RFIDX_W-1:0] disp_i_rs3idx,
   output logic               oitfrd_match_disprs1,
   output logic               oitfrd_match_disprs2,
   output logic               oitfrd_match_disprs3,
   output logic               oitfrd_match_disprd,

   input  logic               ret_ena,
   output logic [ITAG_W-1:0]  ret_ptr,
   output logic [RFIDX_W-1:0] ret_rdidx,
   output logic [PC_W-1:0]    ret_pc,
   output logic               ret_rdwen,
   output logic               ret_rdfpu,

   output logic               oitf_empty
);

   logic [ITAG_W-1:0] alloc_ptr;
   logic              alloc_flag;
   logic              ret_flag;
   logic              alloc_fire;
   logic              ret_fire;
   logic              full;

   logic               entry_valid [DEPTH];
   logic               entry_rdwen [DEPTH];
   logic               entry_rdfpu [DEPTH];
   logic [RFIDX_W-1:0] entry_rdidx [DEPTH];
   logic [PC_W-1:0]    entry_pc    [DEPTH];

   assign oitf_empty = (alloc_ptr == ret_ptr) && (alloc_flag == ret_flag);
   assign full       = (alloc_ptr == ret_ptr) && (alloc_flag != ret_flag);
   assign dis_ready  = ~full;
   assign alloc_fire = dis_ena & dis_ready;
   assign ret_fire   = ret_ena & ~oitf_empty;
   assign dis_ptr    = alloc_ptr;

   e203_exu_oitf_ptr #(.DEPTH(DEPTH), .PTR_W(ITAG_W)) u_alloc_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (alloc_fire),
      .ptr   (alloc_ptr),
      .flag  (alloc_flag)
   );

   e203_exu_oitf_ptr #(.DEPTH(DEPTH), .PTR_W(ITAG_W)) u_ret_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ret_fire),
      .ptr   (ret_ptr),
      .flag  (ret_flag)
   );

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic set_valid;
      logic clr_valid;

      assign set_valid = alloc_fire && (alloc_ptr == ITAG_W'(i));
      assign clr_valid = ret_fire   && (ret_ptr   == ITAG_W'(i));

      // Alloc and retire never target the same slot, since that needs empty or full.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            entry_valid[i] <= 1'b0;
            entry_rdwen[i] <= 1'b0;
            entry_rdfpu[i] <= 1'b0;
            entry_rdidx[i] <= '0;
            entry_pc[i]    <= '0;
         end else if (set_valid) begin
            entry_valid[i] <= 1'b1;
            entry_rdwen[i] <= disp_i_rdwen;
            entry_rdfpu[i] <= disp_i_rdfpu;
            entry_rdidx[i] <= disp_i_rdidx;
            entry_pc[i]    <= disp_i_pc;
         end else if (clr_valid) begin
            entry_valid[i] <= 1'b0;
         end
      end
   end

   assign ret_rdidx = entry_rdidx[ret_ptr];
   assign ret_pc    = entry_pc[ret_ptr];
   assign ret_rdwen = entry_rdwen[ret_ptr];
   assign ret_rdfpu = entry_rdfpu[ret_ptr];

   // Hazard lookup sees only registered entries: a retiring entry still hits,
   // the one being allocated this cycle does not.
   always_comb begin
      logic hit_rs1;
      logic hit_rs2;
      logic hit_rs3;
      logic hit_rd;
      hit_rs1 = 1'b0;
      hit_rs2 = 1'b0;
      hit_rs3 = 1'b0;
      hit_rd  = 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
         if (entry_valid[e] && entry_rdwen[e]) begin
            if ((entry_rdidx[e] == disp_i_rs1idx) && (entry_rdfpu[e] == disp_i_rs1fpu)) hit_rs1 = 1'b1;
            if ((entry_rdidx[e] == disp_i_rs2idx) && (entry_rdfpu[e] == disp_i_rs2fpu)) hit_rs2 = 1'b1;
            if ((entry_rdidx[e] == disp_i_rs3idx) && (entry_rdfpu[e] == disp_i_rs3fpu)) hit_rs3 = 1'b1;
            if ((entry_rdidx[e] == disp_i_rdidx)  && (entry_rdfpu[e] == disp_i_rdfpu))  hit_rd  = 1'b1;
         end
      end
      oitfrd_match_disprs1 = disp_i_rs1en & hit_rs1;
      oitfrd_match_disprs2 = disp_i_rs2en & hit_rs2;
      oitfrd_match_disprs3 = disp_i_rs3en & hit_rs3;
      oitfrd_match_disprd  = disp_i_rdwen & hit_rd;
   end

endmodule

// File: tb/tb_e203_exu_oitf.sv
// Directed self-checking bench for the OITF at DEPTH=2.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_e203_exu_oitf;

   logic        clk;
   logic        rst_n;
   logic        dis_ready;
   logic        dis_ena;
   logic [0:0]  dis_ptr;
   logic        disp_i_rdwen;
   logic        disp_i_rdfpu;
   logic [4:0]  disp_i_rdidx;
   logic [31:0] disp_i_pc;
   logic        disp_i_rs1en, disp_i_rs2en, disp_i_rs3en;
   logic        disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu;
   logic [4:0]  disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx;
   logic        oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprs3;
   logic        oitfrd_match_disprd;
   logic        ret_ena;
   logic [0:0]  ret_ptr;
   logic [4:0]  ret_rdidx;
   logic [31:0] ret_pc;
   logic        ret_rdwen;
   logic        ret_rdfpu;
   logic        oitf_empty;

   int checkCount = 0;
   int errorCount = 0;

   e203_exu_oitf dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .dis_ready            (dis_ready),
      .dis_ena              (dis_ena),
      .dis_ptr              (dis_ptr),
      .disp_i_rdwen         (disp_i_rdwen),
      .disp_i_rdfpu         (disp_i_rdfpu),
      .disp_i_rdidx         (disp_i_rdidx),
      .disp_i_pc            (disp_i_pc),
      .disp_i_rs1en         (disp_i_rs1en),
      .disp_i_rs2en         (disp_i_rs2en),
      .disp_i_rs3en         (disp_i_rs3en),
      .disp_i_rs1fpu        (disp_i_rs1fpu),
      .disp_i_rs2fpu        (disp_i_rs2fpu),
      .disp_i_rs3fpu        (disp_i_rs3fpu),
      .disp_i_rs1idx        (disp_i_rs1idx),
      .disp_i_rs2idx        (disp_i_rs2idx),
      .disp_i_rs3idx        (disp_i_rs3idx),
      .oitfrd_match_disprs1 (oitfrd_match_disprs1),
      .oitfrd_match_disprs2 (oitfrd_match_disprs2),
      .oitfrd_match_disprs3 (oitfrd_match_disprs3),
      .oitfrd_match_disprd  (oitfrd_match_disprd),
      .ret_ena              (ret_ena),
      .ret_ptr              (ret_ptr),
      .ret_rdidx            (ret_rdidx),
      .ret_pc               (ret_pc),
      .ret_rdwen            (ret_rdwen),
      .ret_rdfpu            (ret_rdfpu),
      .oitf_empty           (oitf_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ena, input logic rdwen, input logic [4:0] rdidx,
                                input logic [31:0] pc, input logic ret);
      dis_ena      = ena;
      disp_i_rdwen = rdwen;
      disp_i_rdfpu = 1'b0;
      disp_i_rdidx = rdidx;
      disp_i_pc    = pc;
      ret_ena      = ret;
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   task automatic setSources(input logic en1, input logic fpu1, input logic [4:0] idx1,
                             input logic en2, input logic [4:0] idx2,
                             input logic en3, input logic [4:0] idx3);
      disp_i_rs1en  = en1;
      disp_i_rs1fpu = fpu1;
      disp_i_rs1idx = idx1;
      disp_i_rs2en  = en2;
      disp_i_rs2fpu = 1'b0;
      disp_i_rs2idx = idx2;
      disp_i_rs3en  = en3;
      disp_i_rs3fpu = 1'b0;
      disp_i_rs3idx = idx3;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b1, 5'd5, 32'h0, 1'b0);
      setSources(1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5);
      #12;
      checkOutput("rst_empty",  oitf_empty, 1);
      checkOutput("rst_ready",  dis_ready, 1);
      checkOutput("rst_disptr", dis_ptr, 0);
      checkOutput("rst_retptr", ret_ptr, 0);
      checkOutput("rst_retpc",  ret_pc, 0);
      checkOutput("rst_m1",     oitfrd_match_disprs1, 0);
      checkOutput("rst_m2",     oitfrd_match_disprs2, 0);
      checkOutput("rst_m3",     oitfrd_match_disprs3, 0);
      checkOutput("rst_mrd",    oitfrd_match_disprd, 0);
      rst_n = 1'b1;
      stepClock();

      // Fill: x5 @0x80, then x6 @0x84, then a third that must be dropped
      applyStimulus(1'b1, 1'b1, 5'd5, 32'h80, 1'b0);
      #1 checkOutput("a0_disptr", dis_ptr, 0);
      stepClock();
      checkOutput("a0_disptr_next", dis_ptr, 1);
      checkOutput("a0_empty",  oitf_empty, 0);
      checkOutput("a0_ready",  dis_ready, 1);
      checkOutput("a0_retpc",  ret_pc, 32'h80);
      checkOutput("a0_retrd",  ret_rdidx, 5);
      checkOutput("a0_retwen", ret_rdwen, 1);
      applyStimulus(1'b1, 1'b1, 5'd6, 32'h84, 1'b0);
      stepClock();
      checkOutput("a1_ready",  dis_ready, 0);
      checkOutput("a1_disptr", dis_ptr, 0);
      checkOutput("a1_retpc",  ret_pc, 32'h80);
      applyStimulus(1'b1, 1'b1, 5'd7, 32'h88, 1'b0);
      stepClock();
      checkOutput("a2_ready",  dis_ready, 0);
      checkOutput("a2_disptr", dis_ptr, 0);
      checkOutput("a2_retptr", ret_ptr, 0);
      checkOutput("a2_retpc",  ret_pc, 32'h80);

      // Hazards against x5/x6 integer entries
      applyStimulus(1'b0, 1'b1, 5'd5, 32'h0, 1'b0);
      setSources(1'b1, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 5'd6);
      checkOutput("hz_rs1_int", oitfrd_match_disprs1, 1);
      checkOutput("hz_rs2_off", oitfrd_match_disprs2, 0);
      checkOutput("hz_rs3_x6",  oitfrd_match_disprs3, 1);
      checkOutput("hz_rd_x5",   oitfrd_match_disprd, 1);
      setSources(1'b1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd5);
      checkOutput("hz_rs1_fpu", oitfrd_match_disprs1, 0);
      checkOutput("hz_rs2_x7",  oitfrd_match_disprs2, 0);
      applyStimulus(1'b0, 1'b0, 5'd5, 32'h0, 1'b0);
      #1 checkOutput("hz_rd_nowen", oitfrd_match_disprd, 0);
      applyStimulus(1'b0, 1'b1, 5'd7, 32'h0, 1'b0);
      #1 checkOutput("hz_rd_x7", oitfrd_match_disprd, 0);

      // Drain in order, pointers wrap
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      setSources(1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
      checkOutput("r0_retiring_match", oitfrd_match_disprs1, 1);
      stepClock();
      checkOutput("r0_retpc",  ret_pc, 32'h84);
      checkOutput("r0_retrd",  ret_rdidx, 6);
      checkOutput("r0_retptr", ret_ptr, 1);
      checkOutput("r0_ready",  dis_ready, 1);
      checkOutput("r0_x5gone", oitfrd_match_disprs1, 0);
      stepClock();
      checkOutput("r1_empty",  oitf_empty, 1);
      checkOutput("r1_retptr", ret_ptr, 0);
      checkOutput("r1_disptr", dis_ptr, 0);
      stepClock();
      checkOutput("re_empty",  oitf_empty, 1);
      checkOutput("re_retptr", ret_ptr, 0);
      checkOutput("re_ready",  dis_ready, 1);

      // Occupancy 1, then simultaneous alloc and retire
      applyStimulus(1'b1, 1'b1, 5'd8, 32'h90, 1'b0);
      stepClock();
      checkOutput("o1_disptr", dis_ptr, 1);
      applyStimulus(1'b1, 1'b1, 5'd9, 32'hA0, 1'b1);
      setSources(1'b1, 1'b0, 5'd8, 1'b1, 5'd9, 1'b0, 5'd0);
      checkOutput("ar_retiring_hit", oitfrd_match_disprs1, 1);
      checkOutput("ar_alloc_nohit",  oitfrd_match_disprs2, 0);
      stepClock();
      checkOutput("ar_retptr", ret_ptr, 1);
      checkOutput("ar_disptr", dis_ptr, 0);
      checkOutput("ar_empty",  oitf_empty, 0);
      checkOutput("ar_ready",  dis_ready, 1);
      checkOutput("ar_retpc",  ret_pc, 32'hA0);

      // Two valid, then async reset mid-cycle
      applyStimulus(1'b1, 1'b1, 5'd10, 32'hB0, 1'b0);
      stepClock();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      checkOutput("fr_ready", dis_ready, 0);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("ar_rst_empty",  oitf_empty, 1);
      checkOutput("ar_rst_ready",  dis_ready, 1);
      checkOutput("ar_rst_retptr", ret_ptr, 0);
      checkOutput("ar_rst_disptr", dis_ptr, 0);
      checkOutput("ar_rst_retpc",  ret_pc, 0);
      checkOutput("ar_rst_m1",     oitfrd_match_disprs1, 0);
      stepClock();
      rst_n = 1'b1;
      stepClock();
      checkOutput("post_rst_empty", oitf_empty, 1);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
